mem_access_unit: RTL and testbench

MEM-stage load/store engine between the EX/MEM pipeline register and the MEM/WB register. It converts a pipeline memory operation into a request/acknowledge transaction on the data-memory bus. It generates byte strobes and write-data lanes for stores, and aligns and sign- or zero-extends load data for the MEM/WB `read_data` input. While a transaction is outstanding it stalls the pipeline, and a watchdog counter bounds the wait.

---
 rtl/mem_access_unit.sv | 203 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: turns EX/MEM memory ops into req/ack bus transactions.
// Optional MISALIGN_TRAP_EN: misaligned accesses fault instead of being aligned down.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic [2:0]        funct3_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [31:0]       store_data_in,
  output logic              stall_out,
  output logic [31:0]       read_data_out,
  output logic              fault_out,
  output logic              misaligned_out,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_wstrb,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [ADDR_W-3:0]   addr_q, addr_d;
  logic [1:0]          lo_q, lo_d;
  logic                we_q, we_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  size_t               sz_q, sz_d;
  logic                sext_q, sext_d;
  logic [31:0]         data_q, data_d;
  logic                fault_q, fault_d;
  logic                mis_q, mis_d;

  logic        access, is_wr, trap;
  size_t       sz;
  logic [1:0]  eff_lo;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic [31:0] shifted, ext;

  // Request decode; access is masked during reset so nothing leaks onto the bus.
  always_comb begin
    access = (MemRead_in | MemWrite_in) & reset;
    is_wr  = MemWrite_in & ~MemRead_in;
    case (funct3_in)
      3'b000:  sz = SZ_B;
      3'b001:  sz = SZ_H;
      3'b100:  sz = is_wr ? SZ_W : SZ_B;
      3'b101:  sz = is_wr ? SZ_W : SZ_H;
      default: sz = SZ_W;
    endcase
    case (sz)
      SZ_B:    eff_lo = addr_in[1:0];
      SZ_H:    eff_lo = {addr_in[1], 1'b0};
      default: eff_lo = 2'b00;
    endcase
    case (sz)
      SZ_B:    req_wdata = {4{store_data_in[7:0]}};
      SZ_H:    req_wdata = {2{store_data_in[15:0]}};
      default: req_wdata = store_data_in;
    endcase
    if (!is_wr)          req_wstrb = 4'b0000;
    else if (sz == SZ_B) req_wstrb = 4'b0001 << eff_lo;
    else if (sz == SZ_H) req_wstrb = 4'b0011 << eff_lo;
    else                 req_wstrb = 4'b1111;
`ifdef MISALIGN_TRAP_EN
    trap = access & (((sz == SZ_H) & addr_in[0]) | ((sz == SZ_W) & (addr_in[1:0] != 2'b00)));
`else
    trap = 1'b0;
`endif
  end

  // Load extraction from the captured word using the registered byte offset.
  always_comb begin
    shifted = data_q >> {lo_q, 3'b000};
    case (sz_q)
      SZ_B:    ext = sext_q ? {{24{shifted[7]}}, shifted[7:0]} : {24'h0, shifted[7:0]};
      SZ_H:    ext = sext_q ? {{16{shifted[15]}}, shifted[15:0]} : {16'h0, shifted[15:0]};
      default: ext = data_q;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    lo_d           = lo_q;
    we_d           = we_q;
    wdata_d        = wdata_q;
    wstrb_d        = wstrb_q;
    sz_d           = sz_q;
    sext_d         = sext_q;
    data_d         = data_q;
    fault_d        = fault_q;
    mis_d          = mis_q;
    stall_out      = 1'b0;
    bus_req        = 1'b0;
    bus_we         = 1'b0;
    bus_addr       = '0;
    bus_wdata      = '0;
    bus_wstrb      = '0;
    read_data_out  = '0;
    fault_out      = 1'b0;
    misaligned_out = 1'b0;
    case (state_q)
      IDLE: if (access) begin
        stall_out = 1'b1;
        sz_d      = sz;
        sext_d    = ~funct3_in[2];
        lo_d      = eff_lo;
        if (trap) begin
          data_d  = '0;
          fault_d = 1'b1;
          mis_d   = 1'b1;
          state_d = RESP;
        end else begin
          // An ack arriving in this cycle is deliberately ignored.
          bus_req   = 1'b1;
          bus_we    = is_wr;
          bus_addr  = {addr_in[ADDR_W-1:2], 2'b00};
          bus_wdata = req_wdata;
          bus_wstrb = req_wstrb;
          addr_d    = addr_in[ADDR_W-1:2];
          we_d      = is_wr;
          wdata_d   = req_wdata;
          wstrb_d   = req_wstrb;
          cnt_d     = 8'd0;
          fault_d   = 1'b0;
          mis_d     = 1'b0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        stall_out = 1'b1;
        bus_req   = 1'b1;
        bus_we    = we_q;
        bus_addr  = {addr_q, 2'b00};
        bus_wdata = wdata_q;
        bus_wstrb = wstrb_q;
        if (bus_ack) begin
          data_d  = we_q ? 32'h0 : bus_rdata;
          fault_d = 1'b0;
          state_d = RESP;
        end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          data_d  = '0;
          fault_d = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        read_data_out = ext;
        fault_out     = fault_q;
`ifdef MISALIGN_TRAP_EN
        misaligned_out = mis_q;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      lo_q    <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      sz_q    <= SZ_B;
      sext_q  <= 1'b0;
      data_q  <= '0;
      fault_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      lo_q    <= lo_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      sz_q    <= sz_d;
      sext_q  <= sext_d;
      data_q  <= data_d;
      fault_q <= fault_d;
      mis_q   <= mis_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (TIMEOUT_CYCLES = 4).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead_in, MemWrite_in;
  logic [2:0]  funct3_in;
  logic [31:0] addr_in, store_data_in;
  logic        stall_out, fault_out, misaligned_out;
  logic [31:0] read_data_out;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;

  int n_assert = 0;
  int n_fail   = 0;

  // Per-op observations
  int          r_stall, r_req;
  logic [31:0] r_addr, r_wdata, r_wstrb, r_we, r_req0, r_rd, r_fault, r_mis;

  mem_access_unit #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .funct3_in(funct3_in),
    .addr_in(addr_in), .store_data_in(store_data_in),
    .stall_out(stall_out), .read_data_out(read_data_out),
    .fault_out(fault_out), .misaligned_out(misaligned_out),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Runs one op from IDLE to RESP; ack_k<0 means never ack, else ack in BUSY cycle k.
  task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd,
                       input int ack_k, input logic [31:0] rdata);
    bit done = 0;
    MemRead_in = rd; MemWrite_in = wr; funct3_in = f3; addr_in = a; store_data_in = sd;
    r_stall = 0; r_req = 0;
    for (int i = 0; i < 64 && !done; i++) begin
      bus_ack   = (ack_k >= 0) && (i == ack_k + 1);
      bus_rdata = rdata;
      @(negedge clk);
      if (i == 0) begin
        r_addr = bus_addr; r_wdata = bus_wdata; r_wstrb = {28'h0, bus_wstrb};
        r_we = {31'h0, bus_we}; r_req0 = {31'h0, bus_req};
      end
      if (stall_out) r_stall++;
      if (bus_req) r_req++;
      if (!stall_out) begin
        done = 1;
        r_rd = read_data_out; r_fault = {31'h0, fault_out}; r_mis = {31'h0, misaligned_out};
      end
      @(posedge clk); #1;
    end
    if (!done) chk("op_bound", 32'd0, 32'd1);
    MemRead_in = 0; MemWrite_in = 0; bus_ack = 0;
  endtask

  initial begin
    reset = 0; MemRead_in = 0; MemWrite_in = 0; funct3_in = 0; addr_in = 0;
    store_data_in = 0; bus_ack = 0; bus_rdata = 0;
    repeat (2) @(posedge clk);
    #1 MemRead_in = 1; addr_in = 32'h40;
    @(negedge clk);
    chk("rst_stall", {31'h0, stall_out}, 0);
    chk("rst_req", {31'h0, bus_req}, 0);
    chk("rst_rdata", read_data_out, 0);
    chk("rst_fault", {31'h0, fault_out}, 0);
    chk("rst_mis", {31'h0, misaligned_out}, 0);
    @(posedge clk); #1 MemRead_in = 0; reset = 1;
    @(posedge clk); #1;

    // Reset asserted while BUSY with no ack
    MemRead_in = 1; funct3_in = 3'b010; addr_in = 32'h80;
    @(negedge clk); chk("t1_idle_req", {31'h0, bus_req}, 1);
    @(posedge clk); #1;
    @(negedge clk); chk("t1_busy_req", {31'h0, bus_req}, 1);
    #1 reset = 0;
    #1 chk("t1_req_drop", {31'h0, bus_req}, 0);
    chk("t1_stall_drop", {31'h0, stall_out}, 0);
    @(posedge clk); #1 MemRead_in = 0; reset = 1;
    @(negedge clk);
    chk("t1_post_stall", {31'h0, stall_out}, 0);
    chk("t1_post_req", {31'h0, bus_req}, 0);
    chk("t1_post_rdata", read_data_out, 0);
    @(posedge clk); #1;
    do_op(1, 0, 3'b010, 32'h84, 0, 0, 32'hDEADBEEF);
    chk("t1_next_rd", r_rd, 32'hDEADBEEF);
    chk("t1_next_stall", r_stall, 2);

    // LB / LBU sign handling
    do_op(1, 0, 3'b000, 32'h103, 0, 0, 32'h80FF1234);
    chk("lb_stall", r_stall, 2);
    chk("lb_addr", r_addr, 32'h100);
    chk("lb_wstrb", r_wstrb, 0);
    chk("lb_we", r_we, 0);
    chk("lb_data", r_rd, 32'hFFFFFF80);
    do_op(1, 0, 3'b100, 32'h103, 0, 0, 32'h80FF1234);
    chk("lbu_data", r_rd, 32'h00000080);
    do_op(1, 0, 3'b000, 32'h100, 0, 0, 32'h80FF1234);
    chk("lb0_data", r_rd, 32'h00000034);
    do_op(1, 0, 3'b001, 32'h102, 0, 1, 32'h80FF1234);
    chk("lh_data", r_rd, 32'hFFFF80FF);
    chk("lh_stall", r_stall, 3);
    do_op(1, 0, 3'b101, 32'h102, 0, 0, 32'h80FF1234);
    chk("lhu_data", r_rd, 32'h000080FF);

    // Stores
    do_op(0, 1, 3'b001, 32'h22, 32'h0000ABCD, 3, 0);
    chk("sh_addr", r_addr, 32'h20);
    chk("sh_wdata", r_wdata, 32'hABCDABCD);
    chk("sh_wstrb", r_wstrb, 32'hC);
    chk("sh_we", r_we, 1);
    chk("sh_stall", r_stall, 5);
    do_op(0, 1, 3'b000, 32'h101, 32'h12345655, 0, 0);
    chk("sb_wdata", r_wdata, 32'h55555555);
    chk("sb_wstrb", r_wstrb, 32'h2);
    do_op(0, 1, 3'b010, 32'h30, 32'hCAFEF00D, 1, 0);
    chk("sw_wdata", r_wdata, 32'hCAFEF00D);
    chk("sw_wstrb", r_wstrb, 32'hF);
    chk("sw_fault", r_fault, 0);

    // Read and write both set -> load
    do_op(1, 1, 3'b010, 32'h50, 32'hFFFFFFFF, 0, 32'h0BADF00D);
    chk("rw_we", r_we, 0);
    chk("rw_wstrb", r_wstrb, 0);
    chk("rw_data", r_rd, 32'h0BADF00D);

    // Watchdog timeout
    do_op(1, 0, 3'b010, 32'h40, 0, -1, 32'h55AA55AA);
    chk("to_req", r_req, 5);
    chk("to_stall", r_stall, 5);
    chk("to_fault", r_fault, 1);
    chk("to_data", r_rd, 0);
    chk("to_mis", r_mis, 0);

    // Misaligned accesses
`ifdef MISALIGN_TRAP_EN
    do_op(1, 0, 3'b010, 32'h41, 0, 0, 32'h12345678);
    chk("mis_req", r_req, 0);
    chk("mis_stall", r_stall, 1);
    chk("mis_fault", r_fault, 1);
    chk("mis_flag", r_mis, 1);
    chk("mis_data", r_rd, 0);
    do_op(1, 0, 3'b001, 32'h103, 0, 0, 32'h80FF1234);
    chk("mis_lh_flag", r_mis, 1);
`else
    do_op(1, 0, 3'b010, 32'h41, 0, 0, 32'h12345678);
    chk("mis_addr", r_addr, 32'h40);
    chk("mis_data", r_rd, 32'h12345678);
    chk("mis_fault", r_fault, 0);
    chk("mis_flag", r_mis, 0);
    do_op(1, 0, 3'b001, 32'h103, 0, 0, 32'h80FF1234);
    chk("mis_lh_data", r_rd, 32'hFFFF80FF);
`endif

    // Back-to-back loads
    do_op(1, 0, 3'b010, 32'h10, 0, 0, 32'h11111111);
    chk("b2b_first", r_rd, 32'h11111111);
    do_op(1, 0, 3'b010, 32'h14, 0, 0, 32'h22222222);
    chk("b2b_req0", r_req0, 1);
    chk("b2b_second", r_rd, 32'h22222222);
    chk("b2b_stall", r_stall, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
